dual_port_ram_sc: RTL and testbench

Single-clock, true dual-port synchronous RAM with parametrised data width and depth. Two independent read/write ports share one storage array. Adds a post-reset memory clear sequencer, a per-port read-valid strobe, a selectable cross-port read-during-write mode and write-collision arbitration. It is the general-purpose on-chip buffer for datapath blocks in the same clock domain.

---
 rtl/dual_port_ram_pkg.sv | 20 ++
 rtl/dpram_clear_seq.sv | 55 +++++
 rtl/dual_port_ram_sc.sv | 137 +++++++++++++
 tb/tb_dual_port_ram_sc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for dual_port_ram_sc: read-during-write modes, the
// sequencer state encoding and the parity helper.
package dual_port_ram_pkg;

   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;

   localparam int PAR_MAX_W = 64;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   // Even parity over up to PAR_MAX_W bits; callers zero-extend narrower words.
   function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, writing zero, then
// hands the array over to the ports.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | writing zero to word cnt_q, ports ignored, init_busy high
//   ST_RUN   | normal port operation
module dpram_clear_seq
   import dual_port_ram_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int MEM_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic [MEM_W-1:0]  clr_data
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_CLEAR;
      endcase
   end

   assign init_busy = (state_q == ST_CLEAR);
   assign clr_addr  = cnt_q;
   // All-zero word has zero even parity, so the stored pair is consistent.
   assign clr_data  = '0;

endmodule

// File: rtl/dual_port_ram_sc.sv
// Single-clock true dual-port RAM with post-reset clear, read-valid strobes,
// selectable cross-port read-during-write and write-collision arbitration.
// Optional stored parity bit enabled by defining DPRAM_PARITY_EN.
module dual_port_ram_sc
   import dual_port_ram_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int RD_MODE = READ_FIRST
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_busy,
   input  logic              enA,
   input  logic              wrA,
   input  logic [ADDR_W-1:0] addA,
   input  logic [DATA_W-1:0] dinA,
   input  logic              enB,
   input  logic              wrB,
   input  logic [ADDR_W-1:0] addB,
   input  logic [DATA_W-1:0] dinB,
   output logic [DATA_W-1:0] doutA,
   output logic [DATA_W-1:0] doutB,
   output logic              vldA,
   output logic              vldB,
   output logic              collision
`ifdef DPRAM_PARITY_EN
   ,
   output logic              par_errA,
   output logic              par_errB,
   input  logic              par_injA,
   input  logic              par_injB
`endif
);

   localparam int DEPTH = 2**ADDR_W;
`ifdef DPRAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0]  mem_q [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic [MEM_W-1:0]  clr_data;

   dpram_clear_seq #(
      .ADDR_W (ADDR_W),
      .MEM_W  (MEM_W)
   ) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .clr_data  (clr_data)
   );

   logic run, weA, weB, rdA, rdB, wcol;
   assign run  = !init_busy;
   assign weA  = run & enA & wrA;
   assign weB  = run & enB & wrB;
   assign rdA  = run & enA & ~wrA;
   assign rdB  = run & enB & ~wrB;
   assign wcol = weA & weB & (addA == addB);

   logic [MEM_W-1:0] wordA, wordB;
`ifdef DPRAM_PARITY_EN
   assign wordA = {parity_even(PAR_MAX_W'(dinA)) ^ par_injA, dinA};
   assign wordB = {parity_even(PAR_MAX_W'(dinB)) ^ par_injB, dinB};
`else
   assign wordA = dinA;
   assign wordB = dinB;
`endif

   // Port A wins a same-address write-write; B's write is suppressed.
   always_ff @(posedge clk) begin
      if (clr_we)         mem_q[clr_addr] <= clr_data;
      if (weA)            mem_q[addA]     <= wordA;
      if (weB && !wcol)   mem_q[addB]     <= wordB;
   end

   logic [MEM_W-1:0]  rwordA, rwordB;
   logic [DATA_W-1:0] doutA_q, doutA_d, doutB_q, doutB_d;
   logic              vldA_q, vldB_q, col_q;

   always_comb begin
      rwordA = mem_q[addA];
      rwordB = mem_q[addB];
      if (RD_MODE == WRITE_FIRST && weB && (addB == addA)) rwordA = wordB;
      if (RD_MODE == WRITE_FIRST && weA && (addA == addB)) rwordB = wordA;
      doutA_d = rdA ? rwordA[DATA_W-1:0] : doutA_q;
      doutB_d = rdB ? rwordB[DATA_W-1:0] : doutB_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doutA_q <= '0;
         doutB_q <= '0;
         vldA_q  <= 1'b0;
         vldB_q  <= 1'b0;
         col_q   <= 1'b0;
      end else begin
         doutA_q <= doutA_d;
         doutB_q <= doutB_d;
         vldA_q  <= rdA;
         vldB_q  <= rdB;
         col_q   <= wcol;
      end
   end

   assign doutA     = doutA_q;
   assign doutB     = doutB_q;
   assign vldA      = vldA_q;
   assign vldB      = vldB_q;
   assign collision = col_q;

`ifdef DPRAM_PARITY_EN
   logic perrA_q, perrB_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perrA_q <= 1'b0;
         perrB_q <= 1'b0;
      end else begin
         perrA_q <= rdA & (parity_even(PAR_MAX_W'(rwordA[DATA_W-1:0])) ^ rwordA[DATA_W]);
         perrB_q <= rdB & (parity_even(PAR_MAX_W'(rwordB[DATA_W-1:0])) ^ rwordB[DATA_W]);
      end
   end

   assign par_errA = perrA_q;
   assign par_errB = perrB_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_sc.sv
// Directed bench for dual_port_ram_sc: one READ_FIRST and one WRITE_FIRST
// instance share all stimulus; vectors table plus corner-case sequences.
module tb_dual_port_ram_sc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enA, wrA, enB, wrB;
   logic [2:0] addA, addB;
   logic [7:0] dinA, dinB;

   logic       busy0, vldA0, vldB0, col0;
   logic [7:0] doutA0, doutB0;
   logic       busy1, vldA1, vldB1, col1;
   logic [7:0] doutA1, doutB1;
`ifdef DPRAM_PARITY_EN
   logic       par_injA, par_injB;
   logic       perrA0, perrB0, perrA1, perrB1;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dual_port_ram_sc #(.DATA_W(8), .ADDR_W(3), .RD_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .init_busy(busy0),
      .enA(enA), .wrA(wrA), .addA(addA), .dinA(dinA),
      .enB(enB), .wrB(wrB), .addB(addB), .dinB(dinB),
      .doutA(doutA0), .doutB(doutB0), .vldA(vldA0), .vldB(vldB0),
      .collision(col0)
`ifdef DPRAM_PARITY_EN
      , .par_errA(perrA0), .par_errB(perrB0), .par_injA(par_injA), .par_injB(par_injB)
`endif
   );

   dual_port_ram_sc #(.DATA_W(8), .ADDR_W(3), .RD_MODE(1)) dut_wf (
      .clk(clk), .rst_n(rst_n), .init_busy(busy1),
      .enA(enA), .wrA(wrA), .addA(addA), .dinA(dinA),
      .enB(enB), .wrB(wrB), .addB(addB), .dinB(dinB),
      .doutA(doutA1), .doutB(doutB1), .vldA(vldA1), .vldB(vldB1),
      .collision(col1)
`ifdef DPRAM_PARITY_EN
      , .par_errA(perrA1), .par_errB(perrB1), .par_injA(par_injA), .par_injB(par_injB)
`endif
   );

   typedef struct {
      logic       ena, wra;
      logic [2:0] adda;
      logic [7:0] dina;
      logic       enb, wrb;
      logic [2:0] addb;
      logic [7:0] dinb;
      logic [7:0] eda;
      logic       eva;
      logic [7:0] edb;
      logic       evb;
      logic       ecol;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic set_in(input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
      enA = ea; wrA = wa; addA = aa; dinA = da;
      enB = eb; wrB = wb; addB = ab; dinB = db;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clear(input int idx);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         n++;
         chk("clr_vldA", n, 32'(vldA0), 32'd0);
         chk("clr_vldB", n, 32'(vldB0), 32'd0);
         if (!busy0) done = 1'b1;
      end
      chk("busy_cycles", idx, 32'(n), 32'd8);
      chk("busy_wf", idx, 32'(busy1), 32'd0);
   endtask

   task automatic chk_zero_out(input int idx);
      chk("rst_busy", idx, 32'(busy0), 32'd1);
      chk("rst_doutA", idx, 32'(doutA0), 32'd0);
      chk("rst_doutB", idx, 32'(doutB0), 32'd0);
      chk("rst_vldA", idx, 32'(vldA0), 32'd0);
      chk("rst_vldB", idx, 32'(vldB0), 32'd0);
      chk("rst_col", idx, 32'(col0), 32'd0);
      chk("rst_doutA_wf", idx, 32'(doutA1), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //            ena   wra   adda  dina   enb   wrb   addb  dinb   eda    eva   edb    evb   ecol
      tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 3'd6, 8'h5A, 1'b1, 1'b1, 3'd7, 8'h66, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'h66, 1'b1, 8'h66, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 3'd1, 8'h77, 1'b0, 1'b0, 3'd0, 8'h00, 8'h66, 1'b0, 8'h66, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h77, 1'b1, 8'h66, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 3'd1, 8'hEE, 1'b1, 1'b1, 3'd5, 8'h22, 8'h77, 1'b0, 8'h66, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 8'h77, 1'b1, 8'h22, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 3'd2, 8'h33, 1'b1, 1'b1, 3'd2, 8'h44, 8'h77, 1'b0, 8'h22, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h77, 1'b0, 8'h22, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0};

      idle();
`ifdef DPRAM_PARITY_EN
      par_injA = 1'b0;
      par_injB = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (2) step();
      chk_zero_out(0);

      // Requests presented throughout the clear must be ignored.
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd0, 8'hFF);
      rst_n = 1'b1;
      wait_clear(0);

      foreach (tbl[i]) begin
         set_in(tbl[i].ena, tbl[i].wra, tbl[i].adda, tbl[i].dina,
                tbl[i].enb, tbl[i].wrb, tbl[i].addb, tbl[i].dinb);
         step();
         chk("doutA", i, 32'(doutA0), 32'(tbl[i].eda));
         chk("vldA", i, 32'(vldA0), 32'(tbl[i].eva));
         chk("doutB", i, 32'(doutB0), 32'(tbl[i].edb));
         chk("vldB", i, 32'(vldB0), 32'(tbl[i].evb));
         chk("collision", i, 32'(col0), 32'(tbl[i].ecol));
         chk("doutA_wf", i, 32'(doutA1), 32'(tbl[i].eda));
         chk("doutB_wf", i, 32'(doutB1), 32'(tbl[i].edb));
         chk("collision_wf", i, 32'(col1), 32'(tbl[i].ecol));
      end

      // Cross-port read-during-write: A writes 0x11 to addr 5 (holding 0x22) while B reads it.
      set_in(1'b1, 1'b1, 3'd5, 8'h11, 1'b1, 1'b0, 3'd5, 8'h00);
      step();
      chk("rdw_doutB_rf", 0, 32'(doutB0), 32'h22);
      chk("rdw_doutB_wf", 0, 32'(doutB1), 32'h11);
      chk("rdw_vldB_rf", 0, 32'(vldB0), 32'd1);
      chk("rdw_vldB_wf", 0, 32'(vldB1), 32'd1);
      chk("rdw_vldA", 0, 32'(vldA0), 32'd0);
      set_in(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
      step();
      chk("rdw_after_rf", 1, 32'(doutB0), 32'h11);
      chk("rdw_after_wf", 1, 32'(doutB1), 32'h11);

      // Reverse direction: B writes 0x99 to addr 4 (holding 0x00) while A reads it.
      set_in(1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b1, 3'd4, 8'h99);
      step();
      chk("rdw_doutA_rf", 2, 32'(doutA0), 32'h00);
      chk("rdw_doutA_wf", 2, 32'(doutA1), 32'h99);
      chk("rdw_col", 2, 32'(col0), 32'd0);
      set_in(1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      step();
      chk("rdw_after_rf", 3, 32'(doutA0), 32'h99);
      chk("rdw_after_wf", 3, 32'(doutA1), 32'h99);
      idle();

      // Reset mid-operation, then again at clear cycle 4.
      rst_n = 1'b0;
      #1;
      chk_zero_out(1);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("midclr_busy", 0, 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_zero_out(2);
      step();
      rst_n = 1'b1;
      wait_clear(1);

      set_in(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);
      step();
      chk("cleared_A", 0, 32'(doutA0), 32'h00);
      chk("cleared_vldA", 0, 32'(vldA0), 32'd1);
      chk("cleared_B", 0, 32'(doutB0), 32'h00);
      chk("cleared_vldB", 0, 32'(vldB0), 32'd1);
      idle();
      step();

`ifdef DPRAM_PARITY_EN
      set_in(1'b1, 1'b1, 3'd0, 8'h0F, 1'b0, 1'b0, 3'd0, 8'h00);
      par_injA = 1'b1;
      step();
      par_injA = 1'b0;
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      step();
      chk("par_doutA", 0, 32'(doutA0), 32'h0F);
      chk("par_vldA", 0, 32'(vldA0), 32'd1);
      chk("par_errA_inj", 0, 32'(perrA0), 32'd1);
      chk("par_errB", 0, 32'(perrB0), 32'd0);
      set_in(1'b1, 1'b1, 3'd0, 8'h0F, 1'b0, 1'b0, 3'd0, 8'h00);
      step();
      chk("par_err_wr", 1, 32'(perrA0), 32'd0);
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      step();
      chk("par_vldA", 1, 32'(vldA0), 32'd1);
      chk("par_errA_clean", 1, 32'(perrA0), 32'd0);
      idle();
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
